// File: rtl/eth_gt_rx_link_watchdog.sv
// rtl/eth_gt_rx_link_watchdog.sv - GT RX link supervisor: lock debounce, timed datapath reset, status counters
module eth_gt_rx_link_watchdog #(
  parameter int unsigned LOCK_TIMEOUT = 125000,
  parameter int unsigned UP_HOLD      = 1250,
  parameter int unsigned PULSE_LEN    = 16,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk_125mhz_int,
  input  logic             gt_tx_reset,
  input  logic             watchdog_en,
  input  logic             rx_block_lock,
  input  logic             gt_reset_rx_done,
  input  logic             gt_powergood,
  output logic             rx_datapath_reset,
  output logic             link_up,
  output logic [CNT_W-1:0] retry_count,
  output logic [CNT_W-1:0] link_down_count,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    WAIT_DONE = 3'd0,
    WAIT_LOCK = 3'd1,
    LINK_UP   = 3'd2,
    RST_PULSE = 3'd3,
    WAIT_RST  = 3'd4
  } state_t;

  localparam int                HOLD_W       = $clog2(UP_HOLD + 1);
  localparam logic [31:0]       TIMEOUT_LAST = 32'(LOCK_TIMEOUT - 1);
  localparam logic [31:0]       PULSE_LAST   = 32'(PULSE_LEN - 1);
  localparam logic [HOLD_W-1:0] HOLD_DONE    = HOLD_W'(UP_HOLD);

  logic [1:0]        lock_ff, done_ff, pgood_ff;
  logic              lock_s, done_s, pgood_s;
  state_t            state, state_nxt;
  logic [31:0]       timer, timer_nxt;
  logic [HOLD_W-1:0] hold, hold_nxt;
  logic              retry_inc, down_inc;

  always_ff @(posedge clk_125mhz_int or posedge gt_tx_reset) begin
    if (gt_tx_reset) begin
      lock_ff  <= '0;
      done_ff  <= '0;
      pgood_ff <= '0;
    end else begin
      lock_ff  <= {lock_ff[0], rx_block_lock};
      done_ff  <= {done_ff[0], gt_reset_rx_done};
      pgood_ff <= {pgood_ff[0], gt_powergood};
    end
  end

  assign lock_s  = lock_ff[1];
  assign done_s  = done_ff[1];
  assign pgood_s = pgood_ff[1];

  always_comb begin
    state_nxt = state;
    retry_inc = 1'b0;
    down_inc  = 1'b0;
    unique case (state)
      WAIT_DONE: if (done_s && pgood_s) state_nxt = WAIT_LOCK;
      WAIT_LOCK: begin
        // hold counts completed synced-lock cycles; link is declared on the next locked one
        if (!done_s || !pgood_s) begin
          state_nxt = WAIT_DONE;
        end else if (lock_s && hold == HOLD_DONE) begin
          state_nxt = LINK_UP;
        end else if (watchdog_en && timer == TIMEOUT_LAST) begin
          state_nxt = RST_PULSE;
          retry_inc = 1'b1;
        end
      end
      LINK_UP: begin
        if (!lock_s || !done_s) begin
          state_nxt = WAIT_LOCK;
          down_inc  = 1'b1;
        end
      end
      RST_PULSE: if (timer == PULSE_LAST) state_nxt = WAIT_RST;
      WAIT_RST: begin
        if (done_s) begin
          state_nxt = WAIT_LOCK;
        end else if (timer == TIMEOUT_LAST) begin
          state_nxt = RST_PULSE;
          retry_inc = 1'b1;
        end
      end
      default: state_nxt = WAIT_DONE;
    endcase

    if (state_nxt != state || (state == WAIT_LOCK && !watchdog_en)) timer_nxt = '0;
    else                                                            timer_nxt = timer + 32'd1;

    hold_nxt = (state == WAIT_LOCK && state_nxt == WAIT_LOCK && lock_s) ? hold + 1'b1 : '0;
  end

  always_ff @(posedge clk_125mhz_int or posedge gt_tx_reset) begin
    if (gt_tx_reset) begin
      state             <= WAIT_DONE;
      timer             <= '0;
      hold              <= '0;
      link_up           <= 1'b0;
      rx_datapath_reset <= 1'b0;
      retry_count       <= '0;
      link_down_count   <= '0;
    end else begin
      state             <= state_nxt;
      timer             <= timer_nxt;
      hold              <= hold_nxt;
      link_up           <= (state_nxt == LINK_UP);
      rx_datapath_reset <= (state_nxt == RST_PULSE);
      if (retry_inc && retry_count != '1)    retry_count     <= retry_count + 1'b1;
      if (down_inc && link_down_count != '1) link_down_count <= link_down_count + 1'b1;
    end
  end

  assign state_dbg = state;

endmodule
